// File: rtl/inst_fetch_queue.sv
// -----------------------------------------------------------------------------
// inst_fetch_queue
//
// Sequential instruction fetch unit with a small decoupling queue.
// - Issues one PC request at a time to the I-cache (request held until the
//   response strobe). It stops issuing while the queue is full.
// - Buffers returned {pc, inst} pairs in a QUEUE_DEPTH-entry FIFO.
// - Presents the FIFO head to the decoder over a valid/ready handshake.
// - A jump redirects the PC and flushes the queue. Any response still in
//   flight for the old path is dropped (DISCARD state).
//
// Ports
//   clk, rst_n       clock (rising edge), asynchronous active-low reset
//   rdy              global enable; low freezes every register
//   pc_send_enable   I-cache request valid
//   pc_to_ic         I-cache request address
//   inst_get_ready   I-cache response strobe (one cycle)
//   inst_from_ic     I-cache response instruction
//   inst_valid       queue head valid (queue not empty)
//   inst_to_dec      queue head instruction (0 while empty)
//   pc_to_dec        queue head PC (0 while empty)
//   dec_ready        decoder accepts the head this cycle
//   jump_flag        redirect strobe
//   target_pc        redirect address
//   queue_count      queue occupancy
// -----------------------------------------------------------------------------
module inst_fetch_queue #(
  parameter int unsigned ADDR_WIDTH  = 32,
  parameter int unsigned INST_WIDTH  = 32,
  parameter int unsigned QUEUE_DEPTH = 4,
  parameter int unsigned PC_STEP     = 4,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC = '0
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           rdy,
  output logic                           pc_send_enable,
  output logic [ADDR_WIDTH-1:0]          pc_to_ic,
  input  logic                           inst_get_ready,
  input  logic [INST_WIDTH-1:0]          inst_from_ic,
  output logic                           inst_valid,
  output logic [INST_WIDTH-1:0]          inst_to_dec,
  output logic [ADDR_WIDTH-1:0]          pc_to_dec,
  input  logic                           dec_ready,
  input  logic                           jump_flag,
  input  logic [ADDR_WIDTH-1:0]          target_pc,
  output logic [$clog2(QUEUE_DEPTH):0]   queue_count
);

  localparam int unsigned PTR_W = $clog2(QUEUE_DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_WAIT    = 2'd1;
  localparam logic [1:0] S_DISCARD = 2'd2;

  localparam logic [CNT_W-1:0]      FULL_COUNT = CNT_W'(QUEUE_DEPTH);
  localparam logic [ADDR_WIDTH-1:0] PC_INC     = ADDR_WIDTH'(PC_STEP);
  localparam logic [PTR_W-1:0]      PTR_ONE    = PTR_W'(1);

  logic [1:0]            state_q,     state_d;
  logic [ADDR_WIDTH-1:0] pc_q,        pc_d;
  logic [ADDR_WIDTH-1:0] pc_to_ic_q,  pc_to_ic_d;
  logic                  send_q,      send_d;
  logic [PTR_W-1:0]      head_q,      head_d;
  logic [PTR_W-1:0]      tail_q,      tail_d;
  logic [CNT_W-1:0]      count_q,     count_d;

  logic                  enq;
  logic                  deq;

  logic [ADDR_WIDTH-1:0] pc_mem   [QUEUE_DEPTH];
  logic [INST_WIDTH-1:0] inst_mem [QUEUE_DEPTH];

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: every variable gets a hold default first so no path infers a latch.
    state_d    = state_q;
    pc_d       = pc_q;
    pc_to_ic_d = pc_to_ic_q;
    send_d     = send_q;
    head_d     = head_q;
    tail_d     = tail_q;
    count_d    = count_q;
    enq        = 1'b0;
    deq        = 1'b0;

    if (rdy) begin
      if (jump_flag) begin
        // Redirect wins over everything: flush and suppress this cycle's
        // enqueue/dequeue. A request still outstanding must be drained.
        pc_d    = target_pc;
        head_d  = '0;
        tail_d  = '0;
        count_d = '0;
        send_d  = 1'b0;
        case (state_q)
          S_WAIT,
          S_DISCARD: state_d = inst_get_ready ? S_IDLE : S_DISCARD;
          default:   state_d = S_IDLE;
        endcase
      end else begin
        deq = inst_valid & dec_ready;
        case (state_q)
          S_IDLE: begin
            // Registered count only: a same-cycle dequeue frees a slot for
            // the following cycle, which keeps overflow impossible.
            if (count_q < FULL_COUNT) begin
              pc_to_ic_d = pc_q;
              send_d     = 1'b1;
              state_d    = S_WAIT;
            end else begin
              send_d = 1'b0;
            end
          end
          S_WAIT: begin
            if (inst_get_ready) begin
              enq     = 1'b1;
              pc_d    = pc_q + PC_INC;
              send_d  = 1'b0;
              state_d = S_IDLE;
            end
          end
          S_DISCARD: begin
            send_d = 1'b0;
            if (inst_get_ready) state_d = S_IDLE;
          end
          default: begin
            send_d  = 1'b0;
            state_d = S_IDLE;
          end
        endcase

        if (enq) tail_d = tail_q + PTR_ONE;
        if (deq) head_d = head_q + PTR_ONE;
        case ({enq, deq})
          2'b10:   count_d = count_q + 1'b1;
          2'b01:   count_d = count_q - 1'b1;
          default: count_d = count_q;
        endcase
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Control registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples the pre-edge values computed above.
    if (!rst_n) begin
      state_q    <= S_IDLE;
      pc_q       <= RESET_PC;
      pc_to_ic_q <= '0;
      send_q     <= 1'b0;
      head_q     <= '0;
      tail_q     <= '0;
      count_q    <= '0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      pc_to_ic_q <= pc_to_ic_d;
      send_q     <= send_d;
      head_q     <= head_d;
      tail_q     <= tail_d;
      count_q    <= count_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Queue storage
  // ---------------------------------------------------------------------------
  // NOTE: the storage array is deliberately not reset; an entry is only ever
  // observed after it was written, and the head outputs are masked to 0 while
  // the queue is empty.
  always_ff @(posedge clk) begin
    if (enq) begin
      pc_mem[tail_q]   <= pc_q;
      inst_mem[tail_q] <= inst_from_ic;
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign pc_send_enable = send_q;
  assign pc_to_ic       = pc_to_ic_q;
  assign queue_count    = count_q;
  assign inst_valid     = (count_q != '0);
  assign inst_to_dec    = inst_valid ? inst_mem[head_q] : '0;
  assign pc_to_dec      = inst_valid ? pc_mem[head_q]   : '0;

endmodule

// File: tb/tb_inst_fetch_queue.sv
// -----------------------------------------------------------------------------
// tb_inst_fetch_queue
//
// Directed bench for inst_fetch_queue (default parameters). Inputs are driven
// and outputs sampled on the falling clock edge. The I-cache is mimicked by
// the respond task: it waits for a request, then raises inst_get_ready so
// that the response lands LAT rising edges after the request was registered.
// The response instruction is a fixed function of the requested PC.
// -----------------------------------------------------------------------------
module tb_inst_fetch_queue;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        rdy;
  logic        pc_send_enable;
  logic [31:0] pc_to_ic;
  logic        inst_get_ready;
  logic [31:0] inst_from_ic;
  logic        inst_valid;
  logic [31:0] inst_to_dec;
  logic [31:0] pc_to_dec;
  logic        dec_ready;
  logic        jump_flag;
  logic [31:0] target_pc;
  logic [2:0]  queue_count;

  int tests_run    = 0;
  int tests_failed = 0;

  always #5 clk = ~clk;

  inst_fetch_queue dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .rdy            (rdy),
    .pc_send_enable (pc_send_enable),
    .pc_to_ic       (pc_to_ic),
    .inst_get_ready (inst_get_ready),
    .inst_from_ic   (inst_from_ic),
    .inst_valid     (inst_valid),
    .inst_to_dec    (inst_to_dec),
    .pc_to_dec      (pc_to_dec),
    .dec_ready      (dec_ready),
    .jump_flag      (jump_flag),
    .target_pc      (target_pc),
    .queue_count    (queue_count)
  );

  function automatic logic [31:0] inst_of(input logic [31:0] pc);
    return pc ^ 32'hC0DE_0000;
  endfunction

  task automatic tick;
    @(negedge clk);
  endtask

  task automatic do_reset;
    rst_n = 1'b0; rdy = 1'b1; inst_get_ready = 1'b0; inst_from_ic = '0;
    dec_ready = 1'b0; jump_flag = 1'b0; target_pc = '0;
    tick; tick;
    rst_n = 1'b1;
  endtask

  // Bounded wait for an I-cache request; an expired bound counts as a failure.
  task automatic wait_req;
    int n = 0;
    while (pc_send_enable !== 1'b1 && n < 20) begin tick; n++; end
    tests_run++;
    if (pc_send_enable !== 1'b1) begin
      tests_failed++;
      $display("FAIL req_timeout: pc_send_enable=%b, required 1", pc_send_enable);
    end
  endtask

  task automatic respond(input int lat, output logic [31:0] pc_seen);
    wait_req;
    pc_seen = pc_to_ic;
    repeat (lat - 1) tick;
    inst_get_ready = 1'b1;
    inst_from_ic   = inst_of(pc_seen);
    tick;
    inst_get_ready = 1'b0;
  endtask

  task automatic test_reset;
    rst_n = 1'b0; rdy = 1'b1; inst_get_ready = 1'b0; inst_from_ic = '0;
    dec_ready = 1'b1; jump_flag = 1'b0; target_pc = '0;
    tick; tick;
    tests_run++;
    if ({pc_send_enable, pc_to_ic, inst_valid, queue_count, inst_to_dec, pc_to_dec} !== '0) begin
      tests_failed++;
      $display("FAIL reset_outputs: send=%b pc_to_ic=%h valid=%b count=%0d inst=%h pc=%h, required all 0",
               pc_send_enable, pc_to_ic, inst_valid, queue_count, inst_to_dec, pc_to_dec);
    end
  endtask

  task automatic test_sequential;
    logic [31:0] p;
    do_reset;
    dec_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      respond(2, p);
      tests_run++;
      if (p !== 32'(4 * i)) begin
        tests_failed++; $display("FAIL seq_pc_to_ic[%0d]: got %h, required %h", i, p, 4 * i);
      end
      tests_run++;
      if (inst_valid !== 1'b1 || pc_to_dec !== 32'(4 * i) || inst_to_dec !== inst_of(32'(4 * i)) ||
          queue_count !== 3'd1 || pc_send_enable !== 1'b0) begin
        tests_failed++;
        $display("FAIL seq_head[%0d]: valid=%b pc=%h inst=%h count=%0d send=%b, required 1 %h %h 1 0",
                 i, inst_valid, pc_to_dec, inst_to_dec, queue_count, pc_send_enable,
                 4 * i, inst_of(32'(4 * i)));
      end
      tick;
      tests_run++;
      if (pc_send_enable !== 1'b1 || pc_to_ic !== 32'(4 * i + 4) || queue_count !== 3'd0) begin
        tests_failed++;
        $display("FAIL seq_next_issue[%0d]: send=%b pc_to_ic=%h count=%0d, required 1 %h 0",
                 i, pc_send_enable, pc_to_ic, queue_count, 4 * i + 4);
      end
    end
  endtask

  task automatic test_full_stall;
    logic [31:0] p;
    do_reset;
    dec_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      respond(2, p);
      tests_run++;
      if (p !== 32'(4 * i)) begin
        tests_failed++; $display("FAIL full_pc_to_ic[%0d]: got %h, required %h", i, p, 4 * i);
      end
    end
    tick; tick;
    tests_run++;
    if (pc_send_enable !== 1'b0 || queue_count !== 3'd4 || pc_to_dec !== 32'h0) begin
      tests_failed++;
      $display("FAIL full_stall: send=%b count=%0d head_pc=%h, required 0 4 0",
               pc_send_enable, queue_count, pc_to_dec);
    end
    dec_ready = 1'b1;
    tick;
    dec_ready = 1'b0;
    tests_run++;
    if (queue_count !== 3'd3 || pc_send_enable !== 1'b0 || pc_to_dec !== 32'h4) begin
      tests_failed++;
      $display("FAIL full_one_deq: count=%0d send=%b head_pc=%h, required 3 0 4",
               queue_count, pc_send_enable, pc_to_dec);
    end
    tick;
    tests_run++;
    if (pc_send_enable !== 1'b1 || pc_to_ic !== 32'h10) begin
      tests_failed++;
      $display("FAIL full_resume: send=%b pc_to_ic=%h, required 1 10", pc_send_enable, pc_to_ic);
    end
  endtask

  task automatic test_jump_wait;
    logic [31:0] p;
    do_reset;
    dec_ready = 1'b1;
    wait_req;
    jump_flag = 1'b1; target_pc = 32'h100;
    tick;
    jump_flag = 1'b0;
    tests_run++;
    if (pc_send_enable !== 1'b0 || queue_count !== 3'd0) begin
      tests_failed++;
      $display("FAIL jump_wait_flush: send=%b count=%0d, required 0 0", pc_send_enable, queue_count);
    end
    tick;
    tests_run++;
    if (pc_send_enable !== 1'b0) begin
      tests_failed++;
      $display("FAIL discard_no_issue: send=%b, required 0", pc_send_enable);
    end
    inst_get_ready = 1'b1; inst_from_ic = inst_of(32'h0);
    tick;
    inst_get_ready = 1'b0;
    tests_run++;
    if (inst_valid !== 1'b0 || queue_count !== 3'd0 || pc_send_enable !== 1'b0) begin
      tests_failed++;
      $display("FAIL discard_drop: valid=%b count=%0d send=%b, required 0 0 0",
               inst_valid, queue_count, pc_send_enable);
    end
    tick;
    tests_run++;
    if (pc_send_enable !== 1'b1 || pc_to_ic !== 32'h100 || inst_valid !== 1'b0) begin
      tests_failed++;
      $display("FAIL jump_target_issue: send=%b pc_to_ic=%h valid=%b, required 1 100 0",
               pc_send_enable, pc_to_ic, inst_valid);
    end
    respond(2, p);
    tests_run++;
    if (inst_valid !== 1'b1 || pc_to_dec !== 32'h100 || inst_to_dec !== inst_of(32'h100)) begin
      tests_failed++;
      $display("FAIL jump_first_inst: valid=%b pc=%h inst=%h, required 1 100 %h",
               inst_valid, pc_to_dec, inst_to_dec, inst_of(32'h100));
    end
  endtask

  task automatic test_jump_same_cycle;
    logic [31:0] p;
    do_reset;
    dec_ready = 1'b0;
    respond(2, p);
    respond(2, p);
    wait_req;
    tick;
    tests_run++;
    if (queue_count !== 3'd2 || pc_to_ic !== 32'h8) begin
      tests_failed++;
      $display("FAIL samecyc_setup: count=%0d pc_to_ic=%h, required 2 8", queue_count, pc_to_ic);
    end
    inst_get_ready = 1'b1; inst_from_ic = inst_of(32'h8);
    jump_flag = 1'b1; target_pc = 32'h200; dec_ready = 1'b1;
    tick;
    inst_get_ready = 1'b0; jump_flag = 1'b0; dec_ready = 1'b0;
    tests_run++;
    if (queue_count !== 3'd0 || inst_valid !== 1'b0 || pc_send_enable !== 1'b0 || pc_to_dec !== 32'h0) begin
      tests_failed++;
      $display("FAIL samecyc_flush: count=%0d valid=%b send=%b head_pc=%h, required 0 0 0 0",
               queue_count, inst_valid, pc_send_enable, pc_to_dec);
    end
    tick;
    tests_run++;
    if (pc_send_enable !== 1'b1 || pc_to_ic !== 32'h200) begin
      tests_failed++;
      $display("FAIL samecyc_issue: send=%b pc_to_ic=%h, required 1 200", pc_send_enable, pc_to_ic);
    end
    respond(2, p);
    tests_run++;
    if (queue_count !== 3'd1 || pc_to_dec !== 32'h200) begin
      tests_failed++;
      $display("FAIL samecyc_first: count=%0d head_pc=%h, required 1 200", queue_count, pc_to_dec);
    end
  endtask

  task automatic test_rdy_freeze;
    logic [31:0] p;
    do_reset;
    dec_ready = 1'b0;
    respond(2, p);
    wait_req;
    rdy = 1'b0; dec_ready = 1'b1; jump_flag = 1'b1; target_pc = 32'h300;
    tick;
    jump_flag = 1'b0;
    inst_get_ready = 1'b1; inst_from_ic = inst_of(32'h4);
    tick;
    inst_get_ready = 1'b0;
    tick;
    rdy = 1'b1; dec_ready = 1'b0;
    tests_run++;
    if (pc_send_enable !== 1'b1 || pc_to_ic !== 32'h4 || queue_count !== 3'd1 || pc_to_dec !== 32'h0) begin
      tests_failed++;
      $display("FAIL rdy_freeze: send=%b pc_to_ic=%h count=%0d head_pc=%h, required 1 4 1 0",
               pc_send_enable, pc_to_ic, queue_count, pc_to_dec);
    end
    respond(2, p);
    tests_run++;
    if (p !== 32'h4 || queue_count !== 3'd2 || pc_to_dec !== 32'h0) begin
      tests_failed++;
      $display("FAIL rdy_resume: pc=%h count=%0d head_pc=%h, required 4 2 0", p, queue_count, pc_to_dec);
    end
    wait_req;
    tests_run++;
    if (pc_to_ic !== 32'h8) begin
      tests_failed++;
      $display("FAIL rdy_next_pc: pc_to_ic=%h, required 8", pc_to_ic);
    end
  endtask

  task automatic test_async_reset;
    logic [31:0] p;
    do_reset;
    dec_ready = 1'b0;
    for (int i = 0; i < 4; i++) respond(2, p);
    tick;
    tests_run++;
    if (queue_count !== 3'd4 || inst_valid !== 1'b1) begin
      tests_failed++;
      $display("FAIL areset_setup: count=%0d valid=%b, required 4 1", queue_count, inst_valid);
    end
    #2 rst_n = 1'b0;
    #1;
    tests_run++;
    if ({pc_send_enable, pc_to_ic, inst_valid, queue_count, inst_to_dec, pc_to_dec} !== '0) begin
      tests_failed++;
      $display("FAIL areset_immediate: send=%b pc_to_ic=%h valid=%b count=%0d inst=%h pc=%h, required all 0",
               pc_send_enable, pc_to_ic, inst_valid, queue_count, inst_to_dec, pc_to_dec);
    end
    tick;
    rst_n = 1'b1;
    tick;
    tests_run++;
    if (pc_send_enable !== 1'b1 || pc_to_ic !== 32'h0) begin
      tests_failed++;
      $display("FAIL areset_first_req: send=%b pc_to_ic=%h, required 1 0", pc_send_enable, pc_to_ic);
    end
  endtask

  initial begin
    test_reset;
    test_sequential;
    test_full_stall;
    test_jump_wait;
    test_jump_same_cycle;
    test_rdy_freeze;
    test_async_reset;
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/inst_fetch_queue.md
Name: inst_fetch_queue

Overview:
- Parametrised next-generation instruction fetch unit.
- Issues sequential PC requests to the I-cache and buffers returned instructions in a QUEUE_DEPTH-entry FIFO of {pc, inst} pairs.
- Presents them to the decoder over a valid/ready handshake; stalls when the queue is full.
- Redirects and flushes on jump_flag, and discards an I-cache response already in flight when a jump arrives.

Parameters:
- ADDR_WIDTH, 32, PC/address width.
- INST_WIDTH, 32, instruction width.
- QUEUE_DEPTH, 4, FIFO entries; power of two, >= 2.
- PC_STEP, 4, PC increment per fetched instruction.
- RESET_PC, 0, PC value after reset.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- rdy  in  1  global enable; low freezes the block.
- pc_send_enable  out  1  I-cache request valid; held high until inst_get_ready.
- pc_to_ic  out  ADDR_WIDTH  request address.
- inst_get_ready  in  1  I-cache response strobe (one cycle).
- inst_from_ic  in  INST_WIDTH  response instruction.
- inst_valid  out  1  queue head valid (queue not empty).
- inst_to_dec  out  INST_WIDTH  queue head instruction.
- pc_to_dec  out  ADDR_WIDTH  queue head PC.
- dec_ready  in  1  decoder accepts the head this cycle.
- jump_flag  in  1  redirect strobe.
- target_pc  in  ADDR_WIDTH  redirect address.
- queue_count  out  $clog2(QUEUE_DEPTH)+1  occupancy.

Behaviour:
- Reset (async assert, rst_n low):
  - pc = RESET_PC; state = IDLE.
  - pc_send_enable = 0; pc_to_ic = 0.
  - Queue empty: head = tail = 0, queue_count = 0, inst_valid = 0.
  - inst_to_dec and pc_to_dec read as 0 while empty.
- Deassertion is synchronous to clk. Reset mid-request: the in-flight response is simply ignored, because the I-cache is reset by the same rst_n.
- rdy low: no register changes; inst_get_ready, dec_ready and jump_flag are ignored that cycle.
- FSM states: IDLE, WAIT, DISCARD. At most one outstanding I-cache request.
- IDLE:
  - If queue_count < QUEUE_DEPTH and no jump: pc_to_ic <= pc, pc_send_enable <= 1, go WAIT.
  - Otherwise stay, with pc_send_enable = 0.
  - The check uses registered queue_count; a same-cycle dequeue does not enable issue until the next cycle.
- WAIT:
  - pc_send_enable stays 1.
  - On inst_get_ready: enqueue {pc, inst_from_ic}; pc <= pc + PC_STEP (modulo 2^ADDR_WIDTH); pc_send_enable <= 0; go IDLE.
  - Request-to-enqueue latency = I-cache latency; the next request issues one cycle after the response at the earliest.
- Jump (jump_flag high, rdy high), highest priority:
  - pc <= target_pc; queue flushed (count 0); any same-cycle dequeue or enqueue is suppressed; pc_send_enable <= 0.
  - From IDLE or DISCARD: go IDLE (DISCARD→IDLE only if inst_get_ready is also high that cycle; otherwise stay DISCARD).
  - From WAIT with inst_get_ready the same cycle: the response is dropped; go IDLE.
  - From WAIT without inst_get_ready: go DISCARD.
- DISCARD: pc_send_enable = 0; wait for inst_get_ready, drop the data, go IDLE. No new request issues until then.
- Dequeue: when inst_valid & dec_ready & !jump_flag, head advances and the count decrements. Simultaneous enqueue and dequeue leaves the count unchanged.
- Overflow is impossible: issue requires count < QUEUE_DEPTH and only one request is outstanding.
- Pointers wrap modulo QUEUE_DEPTH.
- Dequeue from an empty queue is ignored.
- inst_to_dec and pc_to_dec are driven from registered queue storage; they are combinational from the head pointer only.

Test Plan:
- Reset, rdy = 1, I-cache latency 2, dec_ready = 1 -> pc_to_ic sequence 0, 4, 8, 12; the decoder sees (0, inst0), (4, inst4)… in order with no gaps beyond the I-cache latency.
- dec_ready = 0, QUEUE_DEPTH = 4 -> exactly 4 enqueues (PCs 0..12); pc_send_enable stays 0 afterwards; queue_count = 4. Raise dec_ready for 1 cycle -> count 3, then the next request has pc_to_ic = 16.
- jump_flag with target_pc = 0x100 while in WAIT, response arriving 2 cycles later -> response dropped; queue_count = 0; next request pc_to_ic = 0x100; no stale instruction reaches the decoder.
- jump_flag in the same cycle as inst_get_ready and a dequeue with count = 2 -> count 0, no DISCARD; next request issues at target_pc one cycle later.
- rdy low for 3 cycles mid-WAIT with inst_get_ready pulsed -> state, queue and PC unchanged; operation resumes identically once rdy = 1.
- Async rst_n pulse between clock edges with a full queue -> outputs zero immediately; after release the first request is pc_to_ic = RESET_PC.
